// File: rtl/periph_uart_tx.sv
// Peripheral-side UART transmitter: queues 16-bit CPU stores in a small FIFO
// and sends each word as two 8N1 bytes, low byte first.
module periph_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      periph_data,
    input  logic             periph_we,
    output logic             tx,
    output logic             busy,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [15:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_s;
    logic             full_r, ovf_r;
    logic             push_s, pop_s, drop_s;

    state_t           state_r, state_s;
    logic [TMR_W-1:0] tmr_r, tmr_s;
    logic [2:0]       idx_r, idx_s;
    logic             byte_sel_r, byte_sel_s;
    logic [15:0]      word_r, word_s;
    logic [7:0]       cur_byte_s;
    logic             tmr_end_s;
    logic             tx_r, tx_s;
    logic             busy_r;

    // FIFO handshake: a write may land on a full FIFO only when the head leaves on the same edge.
    always_comb begin
        pop_s  = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}});
        push_s = periph_we && ((count_r != DEPTH_C) || pop_s);
        drop_s = periph_we && !push_s;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= periph_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            count_r  <= count_s;
            full_r   <= (count_s == DEPTH_C);
            ovf_r    <= ovf_r | drop_s;
        end
    end

    // Transmit FSM next-state, bit timer and line level.
    always_comb begin
        state_s    = state_r;
        tmr_s      = tmr_r;
        idx_s      = idx_r;
        byte_sel_s = byte_sel_r;
        word_s     = word_r;
        tx_s       = 1'b1;
        cur_byte_s = byte_sel_r ? word_r[15:8] : word_r[7:0];
        tmr_end_s  = (tmr_r == TMR_LAST);
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    word_s     = mem_r[rd_ptr_r];
                    byte_sel_s = 1'b0;
                    tmr_s      = {TMR_W{1'b0}};
                    state_s    = ST_START;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (tmr_end_s) begin
                    tmr_s   = {TMR_W{1'b0}};
                    idx_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            ST_DATA: begin
                tx_s = cur_byte_s[idx_r];
                if (tmr_end_s) begin
                    tmr_s = {TMR_W{1'b0}};
                    if (idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (tmr_end_s) begin
                    tmr_s = {TMR_W{1'b0}};
                    if (!byte_sel_r) begin
                        byte_sel_s = 1'b1;
                        state_s    = ST_START;
                    end else begin
                        state_s    = ST_IDLE;
                    end
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                tmr_s   = {TMR_W{1'b0}};
            end
        endcase
    end

    // FSM state and registered line outputs; tx trails the state by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tmr_r      <= {TMR_W{1'b0}};
            idx_r      <= 3'd0;
            byte_sel_r <= 1'b0;
            word_r     <= 16'h0000;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tmr_r      <= tmr_s;
            idx_r      <= idx_s;
            byte_sel_r <= byte_sel_s;
            word_r     <= word_s;
            tx_r       <= tx_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_full  = full_r;
    assign fifo_count = count_r;
    assign overflow   = ovf_r;
endmodule
